// File: rtl/cnn_transpose_seq.sv
// Sequential GF(2) transposed convolution: a latched IN_W x IN_W bit map is scattered one cell
// per cycle, XOR-ing the K x K kernel into an OW x OW accumulator, then handed off over valid/ready.
module cnn_transpose_seq #(
  parameter int IN_W = 4,
  parameter int K    = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [IN_W*IN_W-1:0]                   in_map,
  input  logic [K*K-1:0]                         in_kernel,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [(IN_W+K-1)*(IN_W+K-1)-1:0]       out_map,
  output logic                                   busy
);

  localparam int OW       = IN_W + K - 1;
  localparam int OUT_BITS = OW * OW;
  localparam int CELLS    = IN_W * IN_W;
  localparam int IDX_W    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int SH_W     = $clog2(OUT_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [CELLS-1:0]    map_q;
  logic [K*K-1:0]      kernel_q;
  logic [OUT_BITS-1:0] acc;

  logic [OUT_BITS-1:0] kernel_base;
  logic [OUT_BITS-1:0] window;
  logic [SH_W-1:0]     offset;
  int unsigned         row;
  int unsigned         col;

  // The kernel laid out at the window origin (row stride OW); since j+l never exceeds OW-1,
  // shifting by i*OW+j places it at cell (i,j) with no wrap into the next row.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    kernel_base = '0;
    for (int k = 0; k < K; k++) begin
      for (int l = 0; l < K; l++) begin
        kernel_base[k*OW + l] = kernel_q[k*K + l];
      end
    end
  end

  always_comb begin
    row    = int'(idx) / IN_W;
    col    = int'(idx) % IN_W;
    offset = SH_W'(row * OW + col);
    window = kernel_base << offset;
  end

  assign out_map = acc;

  // Control and datapath share one clocked process so handshake outputs stay registered.
  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      acc       <= '0;
      map_q     <= '0;
      kernel_q  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            map_q    <= in_map;
            kernel_q <= in_kernel;
            acc      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (map_q[idx]) begin
            acc <= acc ^ window;
          end
          idx <= idx + 1'b1;
          if (idx == IDX_W'(CELLS - 1)) begin
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          // Hold the result until the consumer takes it; re-accept only from IDLE.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
